// File: rtl/alarm_manager.sv
// alarm_manager: multi-channel BCD alarm with a ring/snooze/dismiss state machine.
// Define ALARM_SNOOZE_LIMIT_EN to cap snooze presses per alarm event at MAX_SNOOZE.
module alarm_manager #(
  parameter int unsigned NUM_ALARMS       = 2,
  parameter int unsigned SNOOZE_MIN       = 9,
  parameter int unsigned RING_TIMEOUT_MIN = 5,
  parameter int unsigned MAX_SNOOZE       = 3,
  localparam int unsigned ID_W            = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     time_mode_detected,
  input  logic                     min_tick,
  input  logic [15:0]              time_bcd,
  input  logic [16*NUM_ALARMS-1:0] alarm_bcd,
  input  logic [NUM_ALARMS-1:0]    alarm_en,
  input  logic                     snooze_btn,
  input  logic                     dismiss_btn,
  output logic                     activate_alarm,
  output logic                     snoozing,
  output logic [ID_W-1:0]          alarm_id
);

  localparam int unsigned RingCntW = (RING_TIMEOUT_MIN > 1) ? $clog2(RING_TIMEOUT_MIN) : 1;
  localparam int unsigned SnzCntW  = (SNOOZE_MIN > 1) ? $clog2(SNOOZE_MIN) : 1;

  typedef enum logic [1:0] {StIdle, StRinging, StSnooze} state_e;

  state_e                state_q, state_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [RingCntW-1:0]   ring_cnt_q, ring_cnt_d;
  logic [SnzCntW-1:0]    snz_cnt_q, snz_cnt_d;
  logic [NUM_ALARMS-1:0] match_prev_q, eq, rise;
  logic                  activate_q, snoozing_q;
  logic                  trigger;
  logic [ID_W-1:0]       channel;

`ifdef ALARM_SNOOZE_LIMIT_EN
  localparam int unsigned UsedW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  logic [UsedW-1:0] used_q, used_d;
`endif

  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      eq[i] = (time_bcd == alarm_bcd[16*i +: 16]) && alarm_en[i];
    end
    // Edge detect on ungated eq so a mode toggle never re-arms a match.
    rise    = eq & ~match_prev_q;
    trigger = (|rise) && time_mode_detected;
    channel = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (rise[i]) channel = ID_W'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
`ifdef ALARM_SNOOZE_LIMIT_EN
    used_d     = used_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d    = StRinging;
          id_d       = channel;
          ring_cnt_d = '0;
`ifdef ALARM_SNOOZE_LIMIT_EN
          used_d     = '0;
`endif
        end
      end
      StRinging: begin
        if (dismiss_btn) begin
          state_d = StIdle;
        end else if (snooze_btn) begin
`ifdef ALARM_SNOOZE_LIMIT_EN
          if (used_q == UsedW'(MAX_SNOOZE)) begin
            state_d = StIdle;
          end else begin
            state_d   = StSnooze;
            snz_cnt_d = '0;
            used_d    = used_q + 1'b1;
          end
`else
          state_d   = StSnooze;
          snz_cnt_d = '0;
`endif
        end else if (min_tick) begin
          if (ring_cnt_q == RingCntW'(RING_TIMEOUT_MIN - 1)) state_d = StIdle;
          else ring_cnt_d = ring_cnt_q + 1'b1;
        end
      end
      StSnooze: begin
        if (dismiss_btn) begin
          state_d = StIdle;
        end else if (min_tick) begin
          if (snz_cnt_q == SnzCntW'(SNOOZE_MIN - 1)) begin
            state_d    = StRinging;
            ring_cnt_d = '0;
          end else begin
            snz_cnt_d = snz_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Disabling the owning channel overrides every button and tick.
    if (state_q != StIdle && !alarm_en[id_q]) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      id_q         <= '0;
      ring_cnt_q   <= '0;
      snz_cnt_q    <= '0;
      match_prev_q <= '1;
      activate_q   <= 1'b0;
      snoozing_q   <= 1'b0;
`ifdef ALARM_SNOOZE_LIMIT_EN
      used_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      ring_cnt_q   <= ring_cnt_d;
      snz_cnt_q    <= snz_cnt_d;
      match_prev_q <= eq;
      activate_q   <= (state_d == StRinging);
      snoozing_q   <= (state_d == StSnooze);
`ifdef ALARM_SNOOZE_LIMIT_EN
      used_q       <= used_d;
`endif
    end
  end

  assign activate_alarm = activate_q;
  assign snoozing       = snoozing_q;
  assign alarm_id       = id_q;

endmodule
